// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: four-digit multiplexed BCD to 7-segment scanner with ghost guard and leading-zero blanking
module bcd_display_scanner #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        Clk_In,
    input  logic        Resetb_In,
    input  logic [15:0] Bcd_In,
    input  logic        Load_In,
    input  logic        Blank_Lz_In,
    input  logic        Enable_In,
    output logic [6:0]  Seg_Out,
    output logic [3:0]  Dig_Out,
    output logic        Invalid_Out
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [15:0]   shadow_q, shadow_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    dig_q, dig_d;
    logic          inv_q, inv_d;
    logic [3:0]    nib;
    logic [3:0]    zero_from;
    logic          show, blanked;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // Next-state: capture, scan timing, and the registered digit/segment drive
    always_comb begin
        shadow_d  = Load_In ? Bcd_In : shadow_q;
        inv_d     = Load_In ? (Bcd_In[3:0] > 4'd9 || Bcd_In[7:4] > 4'd9 ||
                               Bcd_In[11:8] > 4'd9 || Bcd_In[15:12] > 4'd9) : inv_q;
        cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        idx_d     = (cnt_q == LAST) ? idx_q + 2'd1 : idx_q;
        nib       = shadow_q[idx_q*4 +: 4];
        zero_from[3] = shadow_q[15:12] == 4'd0;
        zero_from[2] = zero_from[3] && shadow_q[11:8] == 4'd0;
        zero_from[1] = zero_from[2] && shadow_q[7:4] == 4'd0;
        zero_from[0] = 1'b0;
        blanked   = Blank_Lz_In && zero_from[idx_q];
        show      = Enable_In && cnt_q != '0;
        dig_d     = show ? 4'b0001 << idx_q : 4'b0000;
        seg_d     = (show && !blanked) ? decode(nib) : 7'h00;
    end

    // State registers, cleared asynchronously so the scan always restarts at digit 0
    always_ff @(posedge Clk_In or negedge Resetb_In) begin
        if (!Resetb_In) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            seg_q    <= '0;
            dig_q    <= '0;
            inv_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            inv_q    <= inv_d;
        end
    end

    assign Seg_Out     = seg_q;
    assign Dig_Out     = dig_q;
    assign Invalid_Out = inv_q;
endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 1000, giving the clocks per digit slot; legal values are 2 or greater.
REQ-002 The module SHALL have port Clk_In, input, width 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port Resetb_In, input, width 1, the reset; reset is asynchronous and active-low.
REQ-004 The module SHALL have port Bcd_In, input, width 16, four BCD digits; [3:0]=digit0 (least significant), up to [15:12]=digit3.
REQ-005 The module SHALL have port Load_In, input, width 1, the capture strobe for Bcd_In.
REQ-006 The module SHALL have port Blank_Lz_In, input, width 1, the leading-zero blanking enable.
REQ-007 The module SHALL have port Enable_In, input, width 1, the display enable.
REQ-008 The module SHALL have port Seg_Out, output reg, width 7, active-high segments in bit order {g,f,e,d,c,b,a}.
REQ-009 The module SHALL have port Dig_Out, output reg, width 4, an active-high one-hot digit enable; bit k drives digit k.
REQ-010 The module SHALL have port Invalid_Out, output reg, width 1, set when the last capture contained a nibble greater than 9.

Function
REQ-011 The block SHALL hold a 16-bit shadow register, loaded from Bcd_In on each rising edge where Load_In=1, and held otherwise.
REQ-012 On the same Load_In edge, the block SHALL load Invalid_Out with 1 if any captured nibble is greater than 9, else 0; it holds between loads.
REQ-013 The scan counter SHALL be clog2(SCAN_DIV) bits wide and count 0..SCAN_DIV-1 every clock, regardless of Enable_In or Load_In.
REQ-014 When the scan counter is at SCAN_DIV-1, it SHALL wrap to 0 on the next edge, and the 2-bit digit index SHALL advance 0->1->2->3->0 on that same edge.
REQ-015 Seg_Out and Dig_Out SHALL be registered: on each edge they are computed from the pre-edge counter, index and shadow values, giving one clock of latency.
REQ-016 Ghost guard: when the pre-edge counter is 0, Dig_Out SHALL be 4'b0000 and Seg_Out SHALL be 7'h00.
REQ-017 Outside the guard cycle, when Enable_In=1, Dig_Out SHALL be the one-hot of the index and Seg_Out SHALL be the decode of the indexed shadow nibble.
REQ-018 The decode SHALL map 0..9 to 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex), and nibbles A..F to 40 (dash, segment g only).
REQ-019 Leading-zero blanking: when Blank_Lz_In=1, digit k (k = 1..3) SHALL be blanked if shadow digits k..3 are all zero; digit 0 is never blanked.
REQ-020 A blanked digit SHALL show Seg_Out=00 while Dig_Out stays one-hot, so the scan timing is unchanged.
REQ-021 When Enable_In=0, Seg_Out and Dig_Out SHALL be 0 from the next edge, while the counter and index keep running.
REQ-022 A Load_In on edge N SHALL be reflected in Seg_Out from edge N+1, including mid-slot, with no restart of the scan.
REQ-023 Dig_Out SHALL never have more than one bit set in any cycle.

Reset
REQ-024 Resetb_In=0 SHALL immediately, without waiting for a clock, clear the shadow, counter, index, Seg_Out, Dig_Out and Invalid_Out to 0.
REQ-025 After Resetb_In rises, the first edge SHALL produce the guard (Dig_Out=0000), and the second edge SHALL produce Dig_Out=0001.
REQ-026 Reset asserted mid-slot SHALL abandon the slot, and scanning SHALL restart from digit 0.

Verification (SCAN_DIV=4)
REQ-027 Load 16'h1234 with Enable_In=1 and Blank_Lz_In=0 -> each slot gives 1 guard clock then 3 clocks of: Dig 0001/Seg 66, Dig 0010/Seg 4F, Dig 0100/Seg 5B, Dig 1000/Seg 06, then repeats.
REQ-028 Load 16'h0050 with Blank_Lz_In=1 -> digits 3 and 2 show Seg 00, digit 1 shows 6D, digit 0 shows 3F; the same load with Blank_Lz_In=0 shows 3F on digits 3 and 2.
REQ-029 Load 16'h9A01 -> Invalid_Out=1 and digit 2 shows 40; a later load of 16'h0001 -> Invalid_Out=0.
REQ-030 Drop Enable_In for 5 clocks during digit 2 -> Seg_Out and Dig_Out are 0 for those clocks, and after Enable_In returns the scan resumes on the index reached as if uninterrupted.
REQ-031 Load 16'h0000 then 16'h8888 in the middle of digit 1's slot -> Seg_Out changes 3F->7F one clock later, with Dig_Out unchanged.
REQ-032 Pulse Resetb_In low between clock edges during digit 3 -> all outputs are 0 asynchronously, then after release the guard cycle occurs, then Dig_Out=0001 with Seg_Out=3F.
